// File: rtl/textmode_pkg.sv
// Shared definitions for the text-mode console path: screen geometry, control codes
// and the console writer state encoding.
package textmode_pkg;

   localparam int COLS          = 80;
   localparam int ROWS          = 30;
   localparam int FONT_W        = 8;
   localparam int FONT_H        = 16;
   localparam int WORDS_PER_ROW = COLS / 4;
   localparam int SB_NWORDS     = ROWS * WORDS_PER_ROW;

   localparam logic [31:0] SPACE_WORD = 32'h2020_2020;

   localparam logic [7:0] CH_BS    = 8'h08;
   localparam logic [7:0] CH_LF    = 8'h0A;
   localparam logic [7:0] CH_FF    = 8'h0C;
   localparam logic [7:0] CH_CR    = 8'h0D;
   localparam logic [7:0] CH_SPACE = 8'h20;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PUT,
      ST_CLR_ROW,
      ST_CLR_ALL
   } console_state_t;

endpackage

// File: rtl/textmode_console_writer.sv
// Byte-stream terminal front end: turns characters and control codes into byte/word
// writes into the write-only GPU screenbuffer while tracking a hardware cursor.
module textmode_console_writer #(
   parameter logic [31:0] SCREENBUFFER_BASE_ADDR = 32'h0001_0000,
   parameter int          COLS                   = textmode_pkg::COLS,
   parameter int          ROWS                   = textmode_pkg::ROWS,
   parameter bit          CLEAR_ON_RESET         = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        char_valid,
   input  logic [7:0]  char_data,
   output logic        char_ready,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   output logic [3:0]  bus_wmask,
   output logic        bus_wen,
   input  logic        bus_ready,
   output logic [6:0]  cursor_col,
   output logic [4:0]  cursor_row,
   output logic        busy
);

   import textmode_pkg::*;

   localparam int             ROW_WORDS    = COLS / 4;
   localparam logic [6:0]     LAST_COL     = 7'(COLS - 1);
   localparam logic [4:0]     LAST_ROW     = 5'(ROWS - 1);
   localparam logic [9:0]     ROW_LAST_OFS = 10'(ROW_WORDS - 1);
   localparam logic [9:0]     LAST_WORD    = 10'(ROWS * ROW_WORDS - 1);
   localparam console_state_t RESET_STATE  = CLEAR_ON_RESET ? ST_CLR_ALL : ST_IDLE;

   // row*20 without a multiplier
   function automatic logic [9:0] row_word(input logic [4:0] r);
      logic [9:0] rr;
      rr = {5'd0, r};
      return (rr << 4) + (rr << 2);
   endfunction

   // row*80 + col without a multiplier
   function automatic logic [11:0] cell_index(input logic [4:0] r, input logic [6:0] c);
      logic [11:0] rr;
      rr = {7'd0, r};
      return (rr << 6) + (rr << 4) + {5'd0, c};
   endfunction

   function automatic logic [31:0] word_addr(input logic [9:0] w);
      return SCREENBUFFER_BASE_ADDR + {20'd0, w, 2'b00};
   endfunction

   console_state_t state_q, state_d;
   logic [6:0]     col_q, col_d;
   logic [4:0]     row_q, row_d;
   logic [9:0]     word_q, word_d;
   logic           put_bs_q, put_bs_d;
   logic [31:0]    bus_addr_q, bus_addr_d;
   logic [31:0]    bus_wdata_q, bus_wdata_d;
   logic [3:0]     bus_wmask_q, bus_wmask_d;
   logic           bus_wen_q, bus_wen_d;

   logic           done;
   logic [4:0]     row_next;
   logic [6:0]     put_col;
   logic [11:0]    cell_idx;
   logic [31:0]    cell_addr;
   logic [3:0]     cell_mask;
   logic           clr_last;

   assign done      = bus_wen_q & bus_ready;
   assign row_next  = (row_q == LAST_ROW) ? 5'd0 : row_q + 5'd1;
   // BS writes its blank one cell to the left of the cursor
   assign put_col   = (char_data == CH_BS) ? col_q - 7'd1 : col_q;
   assign cell_idx  = cell_index(row_q, put_col);
   assign cell_addr = SCREENBUFFER_BASE_ADDR + {20'd0, cell_idx[11:2], 2'b00};
   assign cell_mask = 4'b0001 << cell_idx[1:0];
   assign clr_last  = (state_q == ST_CLR_ALL) ? (word_q == LAST_WORD)
                                              : (word_q == row_word(row_q) + ROW_LAST_OFS);

   always_comb begin
      state_d     = state_q;
      col_d       = col_q;
      row_d       = row_q;
      word_d      = word_q;
      put_bs_d    = put_bs_q;
      bus_addr_d  = bus_addr_q;
      bus_wdata_d = bus_wdata_q;
      bus_wmask_d = bus_wmask_q;
      bus_wen_d   = bus_wen_q;

      case (state_q)
         ST_IDLE: if (char_valid) begin
            case (char_data)
               CH_CR: col_d = 7'd0;
               CH_LF: begin
                  col_d       = 7'd0;
                  row_d       = row_next;
                  word_d      = row_word(row_next);
                  state_d     = ST_CLR_ROW;
                  bus_addr_d  = word_addr(row_word(row_next));
                  bus_wdata_d = SPACE_WORD;
                  bus_wmask_d = 4'hF;
                  bus_wen_d   = 1'b1;
               end
               CH_FF: begin
                  word_d      = 10'd0;
                  state_d     = ST_CLR_ALL;
                  bus_addr_d  = word_addr(10'd0);
                  bus_wdata_d = SPACE_WORD;
                  bus_wmask_d = 4'hF;
                  bus_wen_d   = 1'b1;
               end
               CH_BS: if (col_q != 7'd0) begin
                  col_d       = put_col;
                  put_bs_d    = 1'b1;
                  state_d     = ST_PUT;
                  bus_addr_d  = cell_addr;
                  bus_wdata_d = {4{CH_SPACE}};
                  bus_wmask_d = cell_mask;
                  bus_wen_d   = 1'b1;
               end
               default: begin
                  put_bs_d    = 1'b0;
                  state_d     = ST_PUT;
                  bus_addr_d  = cell_addr;
                  bus_wdata_d = {4{char_data}};
                  bus_wmask_d = cell_mask;
                  bus_wen_d   = 1'b1;
               end
            endcase
         end

         ST_PUT: if (done) begin
            bus_wen_d = 1'b0;
            state_d   = ST_IDLE;
            if (!put_bs_q) begin
               if (col_q == LAST_COL) begin
                  // wrapped onto a new row: blank it before accepting more text
                  col_d       = 7'd0;
                  row_d       = row_next;
                  word_d      = row_word(row_next);
                  state_d     = ST_CLR_ROW;
                  bus_addr_d  = word_addr(row_word(row_next));
                  bus_wdata_d = SPACE_WORD;
                  bus_wmask_d = 4'hF;
                  bus_wen_d   = 1'b1;
               end else begin
                  col_d = col_q + 7'd1;
               end
            end
         end

         ST_CLR_ROW, ST_CLR_ALL: begin
            if (!bus_wen_q) begin
               // entered straight from reset: the start word has not been presented yet
               bus_addr_d  = word_addr(word_q);
               bus_wdata_d = SPACE_WORD;
               bus_wmask_d = 4'hF;
               bus_wen_d   = 1'b1;
            end else if (done) begin
               if (clr_last) begin
                  state_d   = ST_IDLE;
                  bus_wen_d = 1'b0;
                  if (state_q == ST_CLR_ALL) begin
                     col_d = 7'd0;
                     row_d = 5'd0;
                  end
               end else begin
                  word_d     = word_q + 10'd1;
                  bus_addr_d = word_addr(word_q + 10'd1);
               end
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= RESET_STATE;
         col_q       <= 7'd0;
         row_q       <= 5'd0;
         word_q      <= 10'd0;
         put_bs_q    <= 1'b0;
         bus_addr_q  <= 32'd0;
         bus_wdata_q <= 32'd0;
         bus_wmask_q <= 4'd0;
         bus_wen_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         col_q       <= col_d;
         row_q       <= row_d;
         word_q      <= word_d;
         put_bs_q    <= put_bs_d;
         bus_addr_q  <= bus_addr_d;
         bus_wdata_q <= bus_wdata_d;
         bus_wmask_q <= bus_wmask_d;
         bus_wen_q   <= bus_wen_d;
      end
   end

   assign char_ready = (state_q == ST_IDLE);
   assign busy       = ~char_ready;
   assign bus_addr   = bus_addr_q;
   assign bus_wdata  = bus_wdata_q;
   assign bus_wmask  = bus_wmask_q;
   assign bus_wen    = bus_wen_q;
   assign cursor_col = col_q;
   assign cursor_row = row_q;

endmodule

// File: tb/tb_textmode_console_writer.sv
// Directed bench for the console writer: a vector table for single bytes and control
// codes, plus hand sequences for reset clear, stalls, wrap and mid-clear reset.
module tb_textmode_console_writer;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        char_valid = 1'b0;
   logic [7:0]  char_data = 8'h00;
   logic        char_ready;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [3:0]  bus_wmask;
   logic        bus_wen;
   logic        bus_ready = 1'b1;
   logic [6:0]  cursor_col;
   logic [4:0]  cursor_row;
   logic        busy;

   int n_vec = 0;
   int n_err = 0;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  mask;
   } wr_t;
   wr_t wq[$];

   typedef struct {
      logic [7:0]  ch;
      int          nwr;
      logic [31:0] a0;
      logic [31:0] d0;
      logic [3:0]  m0;
      logic [31:0] alast;
      logic [6:0]  col;
      logic [4:0]  row;
   } vec_t;
   vec_t tv[14];

   textmode_console_writer dut (
      .clk        (clk),
      .rst        (rst),
      .char_valid (char_valid),
      .char_data  (char_data),
      .char_ready (char_ready),
      .bus_addr   (bus_addr),
      .bus_wdata  (bus_wdata),
      .bus_wmask  (bus_wmask),
      .bus_wen    (bus_wen),
      .bus_ready  (bus_ready),
      .cursor_col (cursor_col),
      .cursor_row (cursor_row),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // Inputs only change just after rising edges, so the falling edge sees settled values.
   always @(negedge clk) begin
      if (rst && bus_wen && bus_ready)
         wq.push_back('{addr: bus_addr, data: bus_wdata, mask: bus_wmask});
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      n_vec++;
      n_err++;
      $display("FAIL %s: timed out waiting for DUT", name);
   endtask

   function automatic logic [31:0] q_addr(input int i);
      return (i < wq.size()) ? wq[i].addr : 32'hDEAD_DEAD;
   endfunction

   task automatic wait_idle(input string name);
      int t;
      t = 0;
      while (!char_ready && t < 3000) begin
         @(posedge clk); #1;
         t++;
      end
      if (!char_ready) timeout(name);
   endtask

   task automatic send(input logic [7:0] ch);
      wait_idle("send_wait");
      char_valid = 1'b1;
      char_data  = ch;
      @(posedge clk); #1;
      char_valid = 1'b0;
   endtask

   task automatic check_full_clear(input string name);
      int bad;
      bad = 0;
      chk({name, "_count"}, 32'(wq.size()), 32'd600);
      for (int i = 0; i < wq.size(); i++) begin
         if (wq[i].addr !== 32'h10000 + 32'(i * 4) || wq[i].data !== 32'h2020_2020 ||
             wq[i].mask !== 4'hF)
            bad++;
      end
      chk({name, "_seq_bad"}, 32'(bad), 32'd0);
      chk({name, "_last_addr"}, q_addr(599), 32'h1095C);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int bad;
      tv[0]  = '{8'h41, 1,  32'h10000, 32'h4141_4141, 4'h1, 32'h10000, 7'd1, 5'd0};
      tv[1]  = '{8'h42, 1,  32'h10000, 32'h4242_4242, 4'h2, 32'h10000, 7'd2, 5'd0};
      tv[2]  = '{8'h43, 1,  32'h10000, 32'h4343_4343, 4'h4, 32'h10000, 7'd3, 5'd0};
      tv[3]  = '{8'h44, 1,  32'h10000, 32'h4444_4444, 4'h8, 32'h10000, 7'd4, 5'd0};
      tv[4]  = '{8'h45, 1,  32'h10004, 32'h4545_4545, 4'h1, 32'h10004, 7'd5, 5'd0};
      tv[5]  = '{8'h08, 1,  32'h10004, 32'h2020_2020, 4'h1, 32'h10004, 7'd4, 5'd0};
      tv[6]  = '{8'h0D, 0,  32'h0,     32'h0,         4'h0, 32'h0,     7'd0, 5'd0};
      tv[7]  = '{8'h08, 0,  32'h0,     32'h0,         4'h0, 32'h0,     7'd0, 5'd0};
      tv[8]  = '{8'h0A, 20, 32'h10050, 32'h2020_2020, 4'hF, 32'h1009C, 7'd0, 5'd1};
      tv[9]  = '{8'h0A, 20, 32'h100A0, 32'h2020_2020, 4'hF, 32'h100EC, 7'd0, 5'd2};
      tv[10] = '{8'h0A, 20, 32'h100F0, 32'h2020_2020, 4'hF, 32'h1013C, 7'd0, 5'd3};
      tv[11] = '{8'h0A, 20, 32'h10140, 32'h2020_2020, 4'hF, 32'h1018C, 7'd0, 5'd4};
      tv[12] = '{8'h01, 1,  32'h10140, 32'h0101_0101, 4'h1, 32'h10140, 7'd1, 5'd4};
      tv[13] = '{8'h7E, 1,  32'h10140, 32'h7E7E_7E7E, 4'h2, 32'h10140, 7'd2, 5'd4};

      // reset state while rst is held low
      repeat (3) @(posedge clk);
      #1;
      chk("rst_wen",   32'(bus_wen), 32'd0);
      chk("rst_addr",  bus_addr, 32'd0);
      chk("rst_wdata", bus_wdata, 32'd0);
      chk("rst_wmask", 32'(bus_wmask), 32'd0);
      chk("rst_col",   32'(cursor_col), 32'd0);
      chk("rst_row",   32'(cursor_row), 32'd0);
      chk("rst_ready", 32'(char_ready), 32'd0);
      chk("rst_busy",  32'(busy), 32'd1);

      // automatic clear after reset
      wq.delete();
      rst = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_busy", 32'(busy), 32'd1);
      wait_idle("reset_clear");
      check_full_clear("reset_clear");
      chk("reset_clear_ready", 32'(char_ready), 32'd1);

      // vector table: bytes and control codes
      for (int k = 0; k < 14; k++) begin
         wq.delete();
         send(tv[k].ch);
         wait_idle("vec_idle");
         chk($sformatf("vec%0d_nwr", k), 32'(wq.size()), 32'(tv[k].nwr));
         if (tv[k].nwr > 0) begin
            chk($sformatf("vec%0d_addr", k), q_addr(0), tv[k].a0);
            chk($sformatf("vec%0d_data", k), wq[0].data, tv[k].d0);
            chk($sformatf("vec%0d_mask", k), 32'(wq[0].mask), 32'(tv[k].m0));
            chk($sformatf("vec%0d_last", k), q_addr(tv[k].nwr - 1), tv[k].alast);
         end
         chk($sformatf("vec%0d_col", k), 32'(cursor_col), 32'(tv[k].col));
         chk($sformatf("vec%0d_row", k), 32'(cursor_row), 32'(tv[k].row));
      end

      // CR at column 37
      for (int k = 0; k < 35; k++) begin
         send(8'h78);
         wait_idle("cr_fill");
      end
      chk("cr_pre_col", 32'(cursor_col), 32'd37);
      wq.delete();
      send(8'h0D);
      chk("cr_ready", 32'(char_ready), 32'd1);
      chk("cr_col", 32'(cursor_col), 32'd0);
      chk("cr_nwr", 32'(wq.size()), 32'd0);

      // stalled bus on a put, with a competing byte offered meanwhile
      bus_ready = 1'b0;
      wq.delete();
      send(8'h5A);
      chk("stall_wen",  32'(bus_wen), 32'd1);
      chk("stall_addr", bus_addr, 32'h10140);
      chk("stall_data", bus_wdata, 32'h5A5A_5A5A);
      chk("stall_mask", 32'(bus_wmask), 32'd1);
      char_valid = 1'b1;
      char_data  = 8'h51;
      bad = 0;
      for (int k = 0; k < 7; k++) begin
         @(posedge clk); #1;
         if (bus_wen !== 1'b1 || bus_addr !== 32'h10140 || bus_wdata !== 32'h5A5A_5A5A ||
             bus_wmask !== 4'h1 || cursor_col !== 7'd0 || char_ready !== 1'b0)
            bad++;
      end
      chk("stall_stable_bad", 32'(bad), 32'd0);
      char_valid = 1'b0;
      bus_ready  = 1'b1;
      @(posedge clk); #1;
      chk("stall_done_col", 32'(cursor_col), 32'd1);
      chk("stall_done_ready", 32'(char_ready), 32'd1);
      chk("stall_done_wen", 32'(bus_wen), 32'd0);
      @(posedge clk); #1;
      chk("stall_nwr", 32'(wq.size()), 32'd1);
      chk("stall_ignored_col", 32'(cursor_col), 32'd1);

      // FF from (1,4)
      wq.delete();
      send(8'h0C);
      wait_idle("ff_clear");
      check_full_clear("ff_clear");
      chk("ff_col", 32'(cursor_col), 32'd0);
      chk("ff_row", 32'(cursor_row), 32'd0);

      // column wrap off the last row
      for (int k = 0; k < 29; k++) begin
         send(8'h0A);
         wait_idle("wrap_lf");
      end
      chk("wrap_pre_row", 32'(cursor_row), 32'd29);
      for (int k = 0; k < 79; k++) begin
         send(8'h30 + 8'(k % 10));
         wait_idle("wrap_fill");
      end
      chk("wrap_pre_col", 32'(cursor_col), 32'd79);
      wq.delete();
      send(8'h57);
      wait_idle("wrap_last");
      chk("wrap_nwr", 32'(wq.size()), 32'd21);
      chk("wrap_put_addr", q_addr(0), 32'h1095C);
      if (wq.size() > 1) begin
         chk("wrap_put_data", wq[0].data, 32'h5757_5757);
         chk("wrap_put_mask", 32'(wq[0].mask), 32'h8);
         chk("wrap_clr_data", wq[1].data, 32'h2020_2020);
         chk("wrap_clr_mask", 32'(wq[1].mask), 32'hF);
      end
      chk("wrap_clr_first", q_addr(1), 32'h10000);
      chk("wrap_clr_last", q_addr(20), 32'h1004C);
      chk("wrap_col", 32'(cursor_col), 32'd0);
      chk("wrap_row", 32'(cursor_row), 32'd0);

      // reset in the middle of an FF clear
      send(8'h51);
      wait_idle("mid_q");
      send(8'h52);
      wait_idle("mid_r");
      chk("mid_pre_col", 32'(cursor_col), 32'd2);
      wq.delete();
      send(8'h0C);
      begin
         int t;
         t = 0;
         while (wq.size() < 300 && t < 3000) begin
            @(posedge clk); #1;
            t++;
         end
         if (wq.size() < 300) timeout("mid_wait300");
      end
      rst = 1'b0;
      @(posedge clk); #1;
      chk("mid_rst_wen", 32'(bus_wen), 32'd0);
      chk("mid_rst_col", 32'(cursor_col), 32'd0);
      chk("mid_rst_row", 32'(cursor_row), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd1);
      @(posedge clk); #1;
      wq.delete();
      rst = 1'b1;
      wait_idle("mid_reclear");
      check_full_clear("mid_reclear");
      chk("mid_reclear_ready", 32'(char_ready), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/textmode_console_writer.md
# textmode_console_writer

Upstream stage of `bw_textmode_gpu`. Accepts a byte stream of characters and control codes from the CPU side through a valid/ready handshake. Turns each byte into bus-master byte or word writes into the GPU's 80×30 write-only screenbuffer, keeping a hardware cursor. Handles line wrap, CR/LF/BS/FF, and clears rows ahead of the cursor, so firmware gets a terminal without doing any address arithmetic.

## Interface
- `SCREENBUFFER_BASE_ADDR`, default 32'h10000: byte address of character (0,0); must match the GPU.
- `COLS`, default 80: characters per row.
- `ROWS`, default 30: rows per screen.
- `CLEAR_ON_RESET`, default 1: if 1, a full-screen clear runs automatically after reset.
- `clk  in  1`: single clock, same domain as the bus.
- `rst  in  1`: synchronous, active-low reset.
- `char_valid  in  1`: a byte is offered on `char_data`.
- `char_data  in  8`: character or control code.
- `char_ready  out  1`: high only in IDLE; a byte is accepted on a cycle where `char_valid & char_ready`.
- `bus_addr  out  32`: word-aligned write address.
- `bus_wdata  out  32`: write data, byte replicated.
- `bus_wmask  out  4`: byte enables.
- `bus_wen  out  1`: write request; held with addr/data/mask stable until `bus_ready`.
- `bus_ready  in  1`: write complete on a cycle where `bus_wen & bus_ready`.
- `cursor_col  out  7`: current column, 0..COLS-1.
- `cursor_row  out  5`: current row, 0..ROWS-1.
- `busy  out  1`: equals `~char_ready`.

## Operation
- **States:** IDLE, PUT, CLR_ROW, CLR_ALL.
- **IDLE → PUT (printable bytes and BS).** All bytes other than 0x0A, 0x0D, 0x0C go to PUT, including 0x00–0x1F, which print as glyphs.
- **Cell addressing.** Linear index `i = row*80 + col`, 12 bits, max 2399.
  - `bus_addr = BASE + {i[11:2],2'b00}`.
  - `bus_wmask = 4'b0001 << i[1:0]`.
  - `bus_wdata = {4{byte}}`.
- **Printable byte.** Write the byte at the cursor. On completion `col+1`. If `col` was COLS-1: `col=0`, `row=(row+1) mod ROWS`, then go to CLR_ROW for the new row.
- **0x08 BS.**
  - If `col>0`: `col-1`, then write 0x20 at the new position in PUT.
  - If `col==0`: no write, no move, stay in IDLE.
- **0x0D CR.** `col=0` with no bus write; handled in IDLE in one cycle.
- **0x0A LF.** `col=0`, `row=(row+1) mod ROWS`, then CLR_ROW.
- **0x0C FF.** CLR_ALL, then cursor (0,0).
- **CLR_ROW.** 20 word writes of 32'h20202020, `wmask=4'hF`, starting at word `row*20` and incrementing by one. Returns to IDLE after the 20th completion.
- **CLR_ALL.** 600 word writes of 32'h20202020, `wmask=4'hF`, words 0..599 in order, then IDLE.
- **Word counter.** 10 bits, reset to the start word on state entry.
- **Wrap.** Row 29 + LF goes to row 0 and clears row 0. There is no scrolling, because the screenbuffer cannot be read.

## Timing
- **Reset values.**
  - `bus_wen=0`, `bus_addr=0`, `bus_wdata=0`, `bus_wmask=0`, cursor (0,0).
  - With `CLEAR_ON_RESET=1`: state CLR_ALL, so `char_ready=0` and `busy=1` from the first post-reset cycle.
  - With `CLEAR_ON_RESET=0`: state IDLE, `char_ready=1`.
- **Accept to request.** A byte accepted at edge N drives `bus_wen=1` with valid addr/data/mask from cycle N+1 (registered outputs).
- **Bus handshake.**
  - `bus_wen` stays asserted, outputs unchanged, for any number of `bus_ready=0` cycles.
  - On the completion edge the cursor updates; PUT→IDLE drops `bus_wen` the next cycle.
  - In clears, the next word's address is presented the cycle after each completion with `bus_wen` still high. Clears never drop `bus_wen` between words.
- **Minimum cost with a 1-cycle-ready slave.**
  - Printable byte: 2 cycles from accept to `char_ready` again.
  - CLR_ROW: 20 writes.
- **CR latency.** 1 cycle; `char_ready` stays high.
- **Reset mid-operation.** Low `rst` sampled at an edge aborts any write: `bus_wen=0` after that edge. Partial clears are not resumed, except that CLR_ALL restarts per `CLEAR_ON_RESET`.
- **Ignored input.** `char_valid` while busy is ignored; the byte is not consumed.

## Structure
- **Package `textmode_pkg`.** Holds:
  - `COLS`, `ROWS`, `FONT_W`, `FONT_H`.
  - `SB_NWORDS` (600) and `WORDS_PER_ROW` (20).
  - The space word 32'h20202020.
  - Control-code constants.
  - The state enum `console_state_t`.
- The GPU is to be migrated to the same package.
- **No sub-module.** Cursor update and index math are small and kept in this module. `row*80` is implemented as `(row<<6)+(row<<4)`.

## Test plan
- **Reset clear.** Reset with `CLEAR_ON_RESET=1` and `bus_ready` tied high → exactly 600 writes, addresses 0x10000..0x1095C step 4, data 0x20202020, then `char_ready=1`.
- **Byte lanes.** Send 'A','B','C','D','E' at (0,0) → writes at 0x10000 with masks 1,2,4,8 and data 0x41414141 etc., then 0x10004 with mask 1; cursor (5,0).
- **Column wrap.** 80 printable bytes from col 0 row 29 → last byte written at word 599 lane 3, cursor (0,0), followed by 20 clear writes at 0x10000..0x1004C.
- **Stalled bus.** `bus_ready` held low for 7 cycles on a put → `bus_wen`, addr, data, mask stable for all 7 cycles; cursor changes only on the completion edge; `char_valid` is ignored meanwhile.
- **Control codes.**
  - CR at col 37 → col 0, no write.
  - BS at col 0 → nothing.
  - BS at col 5 → write 0x20 to col 4, cursor col 4.
  - LF at row 3 → 20 writes starting at word 80.
- **Mid-clear reset.** Assert `rst=0` during write 300 of an FF clear → `bus_wen=0` the next cycle, cursor (0,0), and a fresh 600-write clear after release.
